// File: rtl/counter_pkg.sv
// Shared types for the event counter bank: counter overflow mode and snapshot FSM states.
package counter_pkg;

  typedef enum logic {
    CNT_WRAP,
    CNT_SATURATE
  } cnt_mode_e;

  typedef enum logic {
    SNAP_IDLE,
    SNAP_SEND
  } snap_state_e;

endpackage

// File: rtl/counter_channel.sv
// Single event counter with clear priority, wrap/saturate overflow and registered terminal-count pulse.
module counter_channel
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter cnt_mode_e   MODE  = CNT_WRAP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             incr_in,
  input  logic             clear_in,
  output logic [WIDTH-1:0] count_out,
  output logic             tc_out
);

  localparam logic [WIDTH-1:0] CNT_ONE    = WIDTH'(1);
  localparam logic [WIDTH-1:0] CNT_MAX    = '1;
  localparam logic [WIDTH-1:0] CNT_MAX_M1 = CNT_MAX - CNT_ONE;

  logic [WIDTH-1:0] r_count;
  logic             r_tc;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
      r_tc    <= 1'b0;
    end else if (clear_in) begin
      r_count <= '0;
      r_tc    <= 1'b0;
    end else if (incr_in) begin
      if (MODE == CNT_SATURATE) begin
        // Pulse only on the step into max, never while holding there.
        if (r_count != CNT_MAX) r_count <= r_count + CNT_ONE;
        r_tc <= (r_count == CNT_MAX_M1);
      end else begin
        r_count <= r_count + CNT_ONE;
        r_tc    <= (r_count == CNT_MAX);
      end
    end else begin
      r_tc <= 1'b0;
    end
  end

  assign count_out = r_count;
  assign tc_out    = r_tc;

endmodule

// File: rtl/event_counter_bank.sv
// Bank of NUM_CH event counters with an atomic snapshot streamed out one channel per AXI-Stream beat.
module event_counter_bank
  import counter_pkg::*;
#(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned WIDTH  = 32,
  parameter cnt_mode_e   MODE   = CNT_WRAP,
  parameter int unsigned IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       incr_in,
  input  logic [NUM_CH-1:0]       clear_in,
  output logic [NUM_CH*WIDTH-1:0] count_out,
  output logic [NUM_CH-1:0]       tc_out,
  input  logic                    snap_req_in,
  output logic                    snap_busy_out,
  output logic                    snap_drop_out,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic [WIDTH-1:0]        m_axis_tdata,
  output logic [IDX_W-1:0]        m_axis_tuser,
  output logic                    m_axis_tlast
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  logic [WIDTH-1:0] w_count [NUM_CH];
  logic [WIDTH-1:0] r_shadow [NUM_CH];
  snap_state_e      r_state;
  logic [IDX_W-1:0] r_idx;
  logic [IDX_W-1:0] w_next_idx;
  logic [WIDTH-1:0] r_tdata;
  logic             r_tvalid;
  logic             r_tlast;
  logic             r_drop;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    counter_channel #(
      .WIDTH (WIDTH),
      .MODE  (MODE)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .incr_in   (incr_in[g]),
      .clear_in  (clear_in[g]),
      .count_out (w_count[g]),
      .tc_out    (tc_out[g])
    );
    assign count_out[g*WIDTH +: WIDTH] = w_count[g];
  end

  assign w_next_idx = r_idx + IDX_ONE;

  // Shadow copy holds pre-increment values, so every channel reflects the same instant.
  always_ff @(posedge clk) begin
    if (!rst && r_state == SNAP_IDLE && snap_req_in) begin
      for (int unsigned i = 0; i < NUM_CH; i++) r_shadow[i] <= w_count[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= SNAP_IDLE;
      r_idx    <= '0;
      r_tdata  <= '0;
      r_tvalid <= 1'b0;
      r_tlast  <= 1'b0;
      r_drop   <= 1'b0;
    end else begin
      r_drop <= snap_req_in && (r_state == SNAP_SEND);
      case (r_state)
        SNAP_IDLE: begin
          if (snap_req_in) begin
            r_state  <= SNAP_SEND;
            r_idx    <= '0;
            r_tdata  <= w_count[0];
            r_tvalid <= 1'b1;
            r_tlast  <= (NUM_CH == 1);
          end
        end
        SNAP_SEND: begin
          if (m_axis_tready) begin
            if (r_tlast) begin
              r_state  <= SNAP_IDLE;
              r_tvalid <= 1'b0;
              r_tlast  <= 1'b0;
            end else begin
              r_idx   <= w_next_idx;
              r_tdata <= r_shadow[w_next_idx];
              r_tlast <= (w_next_idx == LAST_IDX);
            end
          end
        end
        default: r_state <= SNAP_IDLE;
      endcase
    end
  end

  assign snap_busy_out = (r_state == SNAP_SEND);
  assign snap_drop_out = r_drop;
  assign m_axis_tvalid = r_tvalid;
  assign m_axis_tdata  = r_tdata;
  assign m_axis_tuser  = r_idx;
  assign m_axis_tlast  = r_tlast;

endmodule

// File: doc/event_counter_bank.md
Name: event_counter_bank

Overview:
Parametrised multi-channel successor to the single free-running counter. Provides NUM_CH independent event counters with per-channel clear, a selectable wrap or saturate mode, and terminal-count pulses. A snapshot engine captures all channels atomically in one cycle and streams them out over an AXI-Stream-style master port, one beat per channel. It sits beside the datapath as a performance and debug counter block feeding a capture FIFO or DMA.

Parameters:
NUM_CH, 4, number of counter channels (1..16)
WIDTH, 32, counter and stream data width in bits (2..64)
MODE, CNT_WRAP, counter_pkg::cnt_mode_e; CNT_WRAP rolls max->0, CNT_SATURATE holds at max
IDX_W, $clog2(NUM_CH) (minimum 1), channel index width; derived, do not override

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
incr_in  in  NUM_CH  per-channel increment strobe; +1 per cycle when high
clear_in  in  NUM_CH  per-channel synchronous clear to 0
count_out  out  NUM_CH*WIDTH  live counter values; channel i at [i*WIDTH +: WIDTH]
tc_out  out  NUM_CH  one-cycle pulse on terminal count
snap_req_in  in  1  snapshot request strobe
snap_busy_out  out  1  high while snapshot beats are pending
snap_drop_out  out  1  one-cycle pulse when snap_req_in arrives while busy
m_axis_tvalid  out  1  stream beat valid
m_axis_tready  in  1  downstream ready
m_axis_tdata  out  WIDTH  captured counter value
m_axis_tuser  out  IDX_W  channel index of the current beat
m_axis_tlast  out  1  high on the beat for channel NUM_CH-1

Behaviour:
- Reset: all counters 0; tc_out, snap_busy_out, snap_drop_out, m_axis_tvalid, m_axis_tlast = 0; tdata and tuser = 0; FSM in IDLE. Reset mid-snapshot aborts the snapshot; tvalid is 0 in the cycle after rst is sampled.
- Counter update on each clk edge per channel: clear_in has priority over incr_in. With clear_in=1 the next value is 0 and tc does not pulse. With incr_in=1 only, the counter adds 1.
- Wrap mode: count = 2^WIDTH-1 with incr gives next 0, and tc_out pulses in that same next cycle. Saturate mode: the counter holds at max; tc_out pulses only on the 1-cycle transition max-1 -> max, not while holding.
- tc_out is registered and aligned with the count_out update that caused it.
- Snapshot FSM states: IDLE, SEND.
  - IDLE: when snap_req_in=1, copy all count_out values (the values visible in that cycle, before that edge's increments) into shadow registers. Go to SEND with idx=0. tvalid=1 in the next cycle.
  - SEND: tdata = shadow[idx], tuser = idx, tlast = (idx == NUM_CH-1). On tvalid & tready: if tlast, go to IDLE and drop tvalid; otherwise idx+1.
  - While tvalid=1 and tready=0, tdata, tuser and tlast stay stable (AXIS rule).
- snap_busy_out = (state == SEND). A snap_req_in sampled in SEND is ignored and pulses snap_drop_out the next cycle.
- A snap_req_in in the same cycle as the final handshake is dropped, so back-to-back snapshots need one IDLE cycle.
- Minimum snapshot duration is NUM_CH cycles with tready held high. Live counting continues unaffected during SEND.
- NUM_CH=1: tlast is high on every beat; tuser is 0.

Decomposition:
- counter_pkg: typedef enum cnt_mode_e {CNT_WRAP, CNT_SATURATE}; typedef enum snap_state_e {SNAP_IDLE, SNAP_SEND}.
- Sub-module counter_channel (params WIDTH, MODE; ports clk, rst, incr_in, clear_in, count_out, tc_out), instantiated NUM_CH times via generate.
- Snapshot FSM and shadow registers stay in the top level.

Test Plan:
- WIDTH=8, wrap: hold incr_in[0]=1 for 256 cycles from reset -> count ch0 = 0, tc_out[0] pulses exactly once, in the cycle count goes 255 -> 0.
- WIDTH=8, MODE=CNT_SATURATE: 300 increments on ch1 -> count holds 255, exactly one tc_out[1] pulse; then clear_in[1] -> count 0.
- Same-cycle clear_in[2]=1 and incr_in[2]=1 with count 7 -> count 0, no tc pulse.
- NUM_CH=4, counts {5,10,15,20}, snap_req_in with all incr_in=1 and tready=1 -> beats tdata 5,10,15,20, tuser 0..3, tlast only on beat 4; live counts keep incrementing.
- Snapshot with tready toggling 1,0,0,1,... -> tdata, tuser and tlast stable while stalled; exactly 4 beats; snap_req_in during SEND -> snap_drop_out pulse and no second snapshot.
- Assert rst during beat 2 of a snapshot -> tvalid=0 the next cycle, all counts 0, FSM IDLE; a new snap_req_in gives 4 beats of 0.
